// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: mode constants, sizing helpers and
// elaboration-time parameter checks.
`ifndef FIFO_PKG_MACROS
`define FIFO_PKG_MACROS
// Elaboration guard: instantiates a named block that raises $error when cond is false.
`define FIFO_ELAB_CHECK(label, cond, msg) if (!(cond)) begin : label $error(msg); end
`endif

package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit fifo_is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake, data and status bundle between a sync_fifo_param and its user.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int AW = fifo_clog2(DEPTH);

  logic                  io_wr_en;
  logic [DATA_WIDTH-1:0] io_wdata;
  logic                  io_rd_en;
  logic                  io_clr_err;
  logic [DATA_WIDTH-1:0] io_rdata;
  logic                  io_rvalid;
  logic                  io_empty;
  logic                  io_full;
  logic                  io_almost_full;
  logic                  io_almost_empty;
  logic [AW:0]           io_level;
  logic                  io_overflow;
  logic                  io_underflow;

  modport master (
    output io_wr_en, io_wdata, io_rd_en, io_clr_err,
    input  io_rdata, io_rvalid, io_empty, io_full, io_almost_full,
           io_almost_empty, io_level, io_overflow, io_underflow
  );

  modport slave (
    input  io_wr_en, io_wdata, io_rd_en, io_clr_err,
    output io_rdata, io_rvalid, io_empty, io_full, io_almost_full,
           io_almost_empty, io_level, io_overflow, io_underflow
  );
endinterface

// File: rtl/fifo_mem_dp.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 16,
  localparam int AW         = fifo_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through
// read, programmable almost thresholds, fill level and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic               io_clk,
  input  logic               io_rst,
  sync_fifo_param_if.slave   fifo
);

  localparam int AW     = fifo_clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int AE_SAT = (AE_THRESH > DEPTH) ? DEPTH : AE_THRESH;
  localparam logic [LW-1:0] AF_LVL   = AF_THRESH[LW-1:0];
  localparam logic [LW-1:0] AE_LVL   = AE_SAT[LW-1:0];
  localparam logic [LW-1:0] FULL_LVL = DEPTH[LW-1:0];

  `FIFO_ELAB_CHECK(g_chk_depth, fifo_is_pow2(DEPTH) && (DEPTH >= 2), "sync_fifo_param: DEPTH must be a power of two >= 2")
  `FIFO_ELAB_CHECK(g_chk_af, (AF_THRESH >= 0) && (AF_THRESH <= DEPTH), "sync_fifo_param: AF_THRESH must lie in 0..DEPTH")
  `FIFO_ELAB_CHECK(g_chk_ae, AE_THRESH >= 0, "sync_fifo_param: AE_THRESH must be non-negative")
  `FIFO_ELAB_CHECK(g_chk_mode, (FWFT == FIFO_MODE_STD) || (FWFT == FIFO_MODE_FWFT), "sync_fifo_param: FWFT must be 0 or 1")

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Acceptance is gated by the registered flags, so a write while full is
  // dropped even when a read is accepted in the same cycle.
  always_comb begin
    wr_acc   = fifo.io_wr_en & ~full_q;
    rd_acc   = fifo.io_rd_en & ~empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(wr_acc) - LW'(rd_acc);
    empty_d  = (level_d == '0);
    full_d   = (level_d == FULL_LVL);
    af_d     = (level_d >= AF_LVL);
    ae_d     = (level_d <= AE_LVL);
    ovf_d    = (ovf_q & ~fifo.io_clr_err) | (fifo.io_wr_en & full_q);
    udf_d    = (udf_q & ~fifo.io_clr_err) | (fifo.io_rd_en & empty_q);
  end

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= (AF_LVL == '0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (io_clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (fifo.io_wdata),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is shown directly; masked while empty so stale memory never leaks out.
      assign fifo.io_rdata  = empty_q ? '0 : mem_rdata;
      assign fifo.io_rvalid = ~empty_q;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
      logic                  rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rd_acc ? mem_rdata : rdata_q;
        rvalid_d = rd_acc;
      end

      always_ff @(posedge io_clk) begin
        if (io_rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign fifo.io_rdata  = rdata_q;
      assign fifo.io_rvalid = rvalid_q;
    end
  endgenerate

  assign fifo.io_empty        = empty_q;
  assign fifo.io_full         = full_q;
  assign fifo.io_almost_full  = af_q;
  assign fifo.io_almost_empty = ae_q;
  assign fifo.io_level        = level_q;
  assign fifo.io_overflow     = ovf_q;
  assign fifo.io_underflow    = udf_q;

endmodule
